// File: rtl/sdram_glue_pkg.sv
// Shared definitions for the SDRAM read/write glue responder.
// Holds the SDRAM word address/data widths, the responder FSM state encoding
// and the base/size constants of the SDRAM regions the client engines use.
package sdram_glue_pkg;

  // Word address is Bank(2) + Row(13) + Column(9).
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_DONE,
    ST_HOLDOFF
  } glue_state_e;

  // SDRAM regions shared by the drawing and shift engines.
  localparam logic [ADDR_W-1:0] LCD_GRAM_BASE = 24'd0;
  localparam int                LCD_GRAM_SIZE = 384000;
  localparam logic [ADDR_W-1:0] PHOTON_BASE   = 24'd384000;
  localparam int                PHOTON_SIZE   = 600;

endpackage

// File: rtl/sdram_glue_responder_if.sv
// Bus bundle between client engines, the glue responder and the SDRAM
// controller core.
//   client side : iSDRAM_Rd_* / iSDRAM_Wr_* requests, oSDRAM_* done/data
//   controller  : oCmd_* command handshake, iRsp_* completion
//   status      : oTimeout_Err sticky timeout flag
// modport slave  - the responder's view (drives the o* signals)
// modport master - the environment's view (drives the i* signals)
interface sdram_glue_responder_if;
  import sdram_glue_pkg::*;

  logic              iSDRAM_Rd_Req;
  logic [ADDR_W-1:0] iSDRAM_Rd_Addr;
  logic [DATA_W-1:0] oSDRAM_Rd_Data;
  logic              oSDRAM_Rd_Done;
  logic              iSDRAM_Wr_Req;
  logic [ADDR_W-1:0] iSDRAM_Wr_Addr;
  logic [DATA_W-1:0] iSDRAM_Wr_Data;
  logic              oSDRAM_Wr_Done;
  logic              oCmd_Valid;
  logic              iCmd_Ready;
  logic              oCmd_We;
  logic [ADDR_W-1:0] oCmd_Addr;
  logic [DATA_W-1:0] oCmd_WData;
  logic              iRsp_Valid;
  logic [DATA_W-1:0] iRsp_RData;
  logic              oTimeout_Err;

  modport slave (
    input  iSDRAM_Rd_Req, iSDRAM_Rd_Addr, iSDRAM_Wr_Req, iSDRAM_Wr_Addr,
    input  iSDRAM_Wr_Data, iCmd_Ready, iRsp_Valid, iRsp_RData,
    output oSDRAM_Rd_Data, oSDRAM_Rd_Done, oSDRAM_Wr_Done,
    output oCmd_Valid, oCmd_We, oCmd_Addr, oCmd_WData, oTimeout_Err
  );

  modport master (
    output iSDRAM_Rd_Req, iSDRAM_Rd_Addr, iSDRAM_Wr_Req, iSDRAM_Wr_Addr,
    output iSDRAM_Wr_Data, iCmd_Ready, iRsp_Valid, iRsp_RData,
    input  oSDRAM_Rd_Data, oSDRAM_Rd_Done, oSDRAM_Wr_Done,
    input  oCmd_Valid, oCmd_We, oCmd_Addr, oCmd_WData, oTimeout_Err
  );

endinterface

// File: rtl/sdram_rr_arbiter.sv
// Two-requester round-robin grant (read vs write) with a last-served pointer.
//   clk, rst         : clock, synchronous active-high reset
//   rd_req, wr_req   : request levels
//   update,served_wr : pulse update when a transaction completes; served_wr
//                      tells which side it was
//   grant_valid      : any request present
//   grant_wr         : 1 = grant write, 0 = grant read (valid with grant_valid)
module sdram_rr_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  logic wr_req,
  input  logic update,
  input  logic served_wr,
  output logic grant_valid,
  output logic grant_wr
);

  // prefer_wr_q = 1 means the next tie goes to write. Reset favours read.
  logic prefer_wr_q;
  logic prefer_wr_d;

  always_comb begin
    prefer_wr_d = prefer_wr_q;
    if (update) prefer_wr_d = ~served_wr;
  end

  always_ff @(posedge clk) begin
    if (rst) prefer_wr_q <= 1'b0;
    else     prefer_wr_q <= prefer_wr_d;
  end

  assign grant_valid = rd_req | wr_req;
  assign grant_wr    = wr_req & (~rd_req | prefer_wr_q);

endmodule

// File: rtl/sdram_glue_responder.sv
// Target side of the SDRAM read/write glue handshake.
// Arbitrates one level-held read and one level-held write request, issues a
// single-word command to the SDRAM controller core, waits for its completion
// (with a timeout) and returns a one-cycle done pulse to the client.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave view of sdram_glue_responder_if (client + controller)
// Parameters: TIMEOUT = max WAIT_RSP cycles, ERR_DATA = data on timed-out read.
module sdram_glue_responder
  import sdram_glue_pkg::*;
#(
  parameter int                TIMEOUT  = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_glue_responder_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  glue_state_e       state_q,     state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_we_q,    cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] rd_data_q,   rd_data_d;
  logic              rd_done_q,   rd_done_d;
  logic              wr_done_q,   wr_done_d;
  logic              tmo_err_q,   tmo_err_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic grant_valid;
  logic grant_wr;
  logic arb_update;

  sdram_rr_arbiter u_arb (
    .clk        (clk),
    .rst        (rst),
    .rd_req     (bus.iSDRAM_Rd_Req),
    .wr_req     (bus.iSDRAM_Wr_Req),
    .update     (arb_update),
    .served_wr  (cmd_we_q),
    .grant_valid(grant_valid),
    .grant_wr   (grant_wr)
  );

  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    rd_data_d   = rd_data_q;
    rd_done_d   = 1'b0;
    wr_done_d   = 1'b0;
    tmo_err_d   = tmo_err_q;
    cnt_d       = cnt_q;
    arb_update  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Client address/data are captured here only; later changes are ignored.
        if (grant_valid) begin
          cmd_valid_d = 1'b1;
          cmd_we_d    = grant_wr;
          cmd_addr_d  = grant_wr ? bus.iSDRAM_Wr_Addr : bus.iSDRAM_Rd_Addr;
          cmd_wdata_d = grant_wr ? bus.iSDRAM_Wr_Data : '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // No timeout here: a stalled controller is waited on indefinitely.
        if (bus.iCmd_Ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        // Done pulses are raised on the edge into DONE so they line up with it.
        if (bus.iRsp_Valid) begin
          if (!cmd_we_q) rd_data_d = bus.iRsp_RData;
          rd_done_d = ~cmd_we_q;
          wr_done_d = cmd_we_q;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d     = CNT_W'(TIMEOUT);
          tmo_err_d = 1'b1;
          if (!cmd_we_q) rd_data_d = ERR_DATA;
          rd_done_d = ~cmd_we_q;
          wr_done_d = cmd_we_q;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        arb_update = 1'b1;
        state_d    = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        // One dead cycle so a client still holding req after done is not re-granted.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rd_data_q   <= '0;
      rd_done_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_done_q   <= rd_done_d;
      wr_done_q   <= wr_done_d;
      tmo_err_q   <= tmo_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.oCmd_Valid     = cmd_valid_q;
  assign bus.oCmd_We        = cmd_we_q;
  assign bus.oCmd_Addr      = cmd_addr_q;
  assign bus.oCmd_WData     = cmd_wdata_q;
  assign bus.oSDRAM_Rd_Data = rd_data_q;
  assign bus.oSDRAM_Rd_Done = rd_done_q;
  assign bus.oSDRAM_Wr_Done = wr_done_q;
  assign bus.oTimeout_Err   = tmo_err_q;

endmodule

// File: doc/sdram_glue_responder.md
Name: sdram_glue_responder

Overview:
- Target side of the SDRAM read/write glue handshake used by the drawing and shift engines.
- Accepts one level-held read request and one level-held write request from a client. Each request carries a 24-bit address (Bank 2 + Row 13 + Column 9).
- Arbitrates between the two, issues single-word commands to the SDRAM controller core, and returns one-cycle done pulses. Read data is returned with the read done pulse.
- Sits between client engines and the SDRAM controller core.

Parameters:
- ADDR_W, 24, SDRAM word address width (Bank+Row+Column).
- DATA_W, 16, SDRAM data width.
- TIMEOUT, 1023, maximum cycles to wait for a controller response before forced completion.
- ERR_DATA, 16'hDEAD, read data returned on a timed-out read.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- iSDRAM_Rd_Req  in  1  client read request; level, held until done.
- iSDRAM_Rd_Addr  in  ADDR_W  client read address.
- oSDRAM_Rd_Data  out  DATA_W  read data; valid while oSDRAM_Rd_Done=1, held afterwards.
- oSDRAM_Rd_Done  out  1  one-cycle read completion pulse.
- iSDRAM_Wr_Req  in  1  client write request; level, held until done.
- iSDRAM_Wr_Addr  in  ADDR_W  client write address.
- iSDRAM_Wr_Data  in  DATA_W  client write data.
- oSDRAM_Wr_Done  out  1  one-cycle write completion pulse.
- oCmd_Valid  out  1  command valid to controller.
- iCmd_Ready  in  1  controller accepts the command when oCmd_Valid&iCmd_Ready.
- oCmd_We  out  1  1=write, 0=read.
- oCmd_Addr  out  ADDR_W  command address.
- oCmd_WData  out  DATA_W  write data.
- iRsp_Valid  in  1  controller completion, one per command, in order.
- iRsp_RData  in  DATA_W  read data, qualified by iRsp_Valid.
- oTimeout_Err  out  1  sticky; set on any timeout, cleared only by rst.

Behaviour:
- Reset values: every output is 0, FSM is IDLE, round-robin pointer favours read, timeout counter is 0.
- FSM states: IDLE, ISSUE, WAIT_RSP, DONE, HOLDOFF.
- IDLE:
  - If exactly one request is high, grant it.
  - If both are high, grant the side not served last (round-robin). The first tie after reset goes to read.
  - On grant, register oCmd_We/oCmd_Addr/oCmd_WData from the granted client inputs, set oCmd_Valid=1, and go to ISSUE.
  - Client address and data are sampled only at grant; later changes are ignored.
- ISSUE:
  - Hold oCmd_* stable until iCmd_Ready=1.
  - On the accepting cycle, oCmd_Valid goes to 0 next cycle; clear the timeout counter and go to WAIT_RSP.
- WAIT_RSP:
  - On iRsp_Valid, latch iRsp_RData into oSDRAM_Rd_Data (reads only) and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, set oTimeout_Err, load ERR_DATA for a read, and go to DONE.
  - The timeout applies only in WAIT_RSP; ISSUE waits indefinitely.
- DONE:
  - Assert oSDRAM_Rd_Done or oSDRAM_Wr_Done for exactly one cycle, matching the granted side.
  - Update the round-robin pointer, then go to HOLDOFF.
- HOLDOFF:
  - Exactly one cycle, ignoring both requests. This covers clients that drop req in the cycle after seeing done.
  - Then go to IDLE.
- Minimum cycles from req to done, with iCmd_Ready=1 at once and iRsp_Valid the cycle after acceptance: 4 (IDLE, ISSUE, WAIT_RSP, DONE pulse). Back-to-back transactions start every 5 cycles.
- Rd_Done and Wr_Done are never high together. Exactly one outstanding command at a time.
- A request dropped by the client before done: the transaction still completes and still pulses done.
- A stray iRsp_Valid outside WAIT_RSP is ignored.
- rst mid-transaction: return to IDLE, deassert oCmd_Valid, clear done pulses, clear oTimeout_Err. Any controller response that arrives later is ignored.

Decomposition:
- Shared package sdram_glue_pkg holds:
  - ADDR_W/DATA_W constants;
  - FSM state enumeration;
  - the region base constants: LCD GRAM base 0, size 384000; photon counter base 384000, size 600.
- One natural sub-module: sdram_rr_arbiter, a two-requester round-robin grant with a last-served pointer.

Test Plan:
- Single read at 384001, iCmd_Ready=1, iRsp_Valid one cycle after acceptance with 0x1234 -> oCmd_We=0, oCmd_Addr=384001; Rd_Done pulses 4 cycles after req with oSDRAM_Rd_Data=0x1234.
- Single write at 384599 with data 0x00AB, iCmd_Ready low for 3 cycles -> oCmd_* stable through the stall, one command issued with We=1; one Wr_Done pulse.
- Rd and Wr held simultaneously for 4 transactions -> grants alternate R,W,R,W; never two done pulses in the same cycle.
- Client holds req one cycle past done (shift-engine behaviour) over a 600-iteration read/write loop -> exactly 600 reads and 600 writes issued, no duplicates.
- No iRsp_Valid after a read is accepted -> Rd_Done pulses after TIMEOUT cycles with data 0xDEAD and oTimeout_Err=1 sticky; the next transaction completes normally.
- rst asserted during WAIT_RSP, then a late iRsp_Valid -> no done pulse, outputs zero, next request serviced cleanly.
